// File: rtl/soc_design_pio_pkg.sv
// rtl/soc_design_pio_pkg.sv - shared register map and edge-type encodings for the PIO slaves
package soc_design_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_design_pio_sync.sv
// rtl/soc_design_pio_sync.sv - WIDTH x STAGES flop synchronizer with async active-low reset
module soc_design_pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/soc_design_pio_in.sv
// rtl/soc_design_pio_in.sv - Avalon-MM input PIO with sticky edge capture and masked level irq
module soc_design_pio_in
  import soc_design_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] ARM_TERM = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [CNT_W-1:0] arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  soc_design_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_in)
  );

  // Edges are ignored until the synchronizer and prev_in both hold post-reset samples.
  assign armed = (arm_cnt == ARM_TERM);
  assign wr_en = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = sync_in & ~prev_in;
      EDGE_FALL: edge_det = ~sync_in & prev_in;
      default:   edge_det = sync_in ^ prev_in;
    endcase
    if (!armed) edge_det = '0;
  end

  always_comb begin
    clr_bits = '0;
    if (wr_en && address == ADDR_EDGE)
      clr_bits = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next = 32'(sync_in);
      ADDR_MASK: rd_next = 32'(irq_mask);
      ADDR_EDGE: rd_next = 32'(edgecapture);
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_in     <= '0;
      arm_cnt     <= '0;
      irq_mask    <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      prev_in  <= sync_in;
      readdata <= rd_next;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      if (wr_en && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      // OR-ing the new edges after the clear lets a same-cycle edge survive the clear.
      edgecapture <= (edgecapture & ~clr_bits) | edge_det;
    end
  end

  assign irq = |(edgecapture & irq_mask);

endmodule

// File: tb/tb_soc_design_pio_in.sv
// tb/tb_soc_design_pio_in.sv - self-checking bench for soc_design_pio_in (rising/BC=1 and any-edge/BC=0 instances)
module tb_soc_design_pio_in;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [7:0]  in_port = 8'h00;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  soc_design_pio_in #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .BIT_CLEAR(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  soc_design_pio_in #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2), .BIT_CLEAR(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  // Reference model: history of in_port samples taken since reset release.
  logic [7:0]  samp[$];
  logic [7:0]  m_mask [2];
  logic [7:0]  m_ecap [2];
  logic [31:0] m_rd   [2];
  int          m_etype [2] = '{0, 2};
  int          m_bc    [2] = '{1, 0};

  function automatic logic [7:0] m_sync(int i);
    if (i >= S && (i - S) < samp.size()) return samp[i - S];
    return 8'h00;
  endfunction

  task automatic model_reset();
    samp.delete();
    for (int k = 0; k < 2; k++) begin
      m_mask[k] = 8'h00; m_ecap[k] = 8'h00; m_rd[k] = 32'h0;
    end
  endtask

  task automatic model_step();
    int j;
    logic [7:0] s1, s2, ev, clr;
    logic wr;
    j  = samp.size() + 1;
    s1 = m_sync(j - 1);
    s2 = m_sync(j - 2);
    wr = chipselect && !write_n;
    for (int k = 0; k < 2; k++) begin
      if (j - 1 < S + 1) ev = 8'h00;
      else if (m_etype[k] == 0) ev = s1 & ~s2;
      else if (m_etype[k] == 1) ev = ~s1 & s2;
      else ev = s1 ^ s2;
      case (address)
        2'd0: m_rd[k] = {24'h0, s1};
        2'd2: m_rd[k] = {24'h0, m_mask[k]};
        2'd3: m_rd[k] = {24'h0, m_ecap[k]};
        default: m_rd[k] = 32'h0;
      endcase
      if (wr && address == 2'd2) m_mask[k] = writedata[7:0];
      clr = (wr && address == 2'd3) ? ((m_bc[k] != 0) ? writedata[7:0] : 8'hFF) : 8'h00;
      m_ecap[k] = (m_ecap[k] & ~clr) | ev;
    end
    samp.push_back(in_port);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check("model_rd0", rd0, m_rd[0]);
    check("model_irq0", {31'h0, irq0}, {31'h0, |(m_ecap[0] & m_mask[0])});
    check("model_rd1", rd1, m_rd[1]);
    check("model_irq1", {31'h0, irq1}, {31'h0, |(m_ecap[1] & m_mask[1])});
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
  endtask

  task automatic bus_rd(logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1; writedata = 32'h0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h0000_00FF};
    vecs[2] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 2'd1, 32'h0,         1'b1, 32'h0};
    vecs[5] = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h0000_00FF};
    vecs[6] = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h0000_0084};
    vecs[7] = '{1'b1, 2'd2, 32'h0000_0004, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h0000_0004};

    // Reset and arm with pins held high
    model_reset();
    in_port = 8'hFF;
    repeat (3) tick();
    reset_n = 1'b1;
    bus_rd(2'd3);
    repeat (10) tick();
    check("arm_ecap", rd0, 32'h0);
    check("arm_irq", {31'h0, irq0}, 32'h0);
    check("arm_ecap_any", rd1, 32'h0);
    bus_rd(2'd0);
    tick();
    check("arm_data", rd0, 32'h0000_00FF);

    // Rising capture, irq via mask, write-1-to-clear
    in_port = 8'h00;
    repeat (4) tick();
    bus_wr(2'd3, 32'hFF); tick();
    bus_wr(2'd2, 32'h04); tick();
    bus_rd(2'd3);
    in_port = 8'h05;
    repeat (2) tick();
    check("rise_irq_early", {31'h0, irq0}, 32'h0);
    tick();
    check("rise_irq", {31'h0, irq0}, 32'h1);
    tick();
    check("rise_ecap", rd0, 32'h05);
    bus_wr(2'd3, 32'h04); tick();
    bus_rd(2'd3); tick();
    check("w1c_ecap", rd0, 32'h01);
    check("w1c_irq", {31'h0, irq0}, 32'h0);

    // Clear colliding with a fresh rising edge on bit 0
    in_port = 8'h04;
    bus_wr(2'd3, 32'h01); tick();
    bus_rd(2'd3); repeat (4) tick();
    check("coll_pre", rd0, 32'h0);
    in_port = 8'h05;
    repeat (2) tick();
    bus_wr(2'd3, 32'h01); tick();
    bus_rd(2'd3); tick();
    check("coll_set_wins", rd0, 32'h01);

    // Clear-all on the BIT_CLEAR=0 instance, any-edge pulse
    bus_wr(2'd3, 32'hFF); tick();
    bus_rd(2'd3);
    in_port = 8'h84;
    repeat (4) tick();
    check("bc0_pre", rd1, 32'h81);
    check("bc1_pre", rd0, 32'h80);
    bus_wr(2'd3, 32'h0); tick();
    bus_rd(2'd3); tick();
    check("bc0_clear_all", rd1, 32'h0);
    check("bc1_zero_write", rd0, 32'h80);
    in_port = 8'h8C;
    repeat (3) tick();
    bus_rd(2'd3); tick();
    check("any_rise", rd1, 32'h08);
    bus_wr(2'd3, 32'h0); tick();
    in_port = 8'h84;
    bus_rd(2'd3); tick();
    check("any_cleared", rd1, 32'h0);
    repeat (3) tick();
    check("any_fall", rd1, 32'h08);

    // Register map table
    bus_rd(2'd0);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata);
      else bus_rd(vecs[i].addr);
      tick();
      if (vecs[i].chk) check($sformatf("vec%0d", i), rd0, vecs[i].exp);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      address    = 2'($urandom);
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      tick();
    end

    // Reset asserted between clock edges
    bus_wr(2'd2, 32'hFF); tick();
    bus_rd(2'd3);
    in_port = 8'h00; repeat (4) tick();
    in_port = 8'hFF; repeat (4) tick();
    check("mid_ecap", rd0, 32'hFF);
    check("mid_irq", {31'h0, irq0}, 32'h1);
    bus_rd(2'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async_irq", {31'h0, irq0}, 32'h0);
    check("async_rd", rd0, 32'h0);
    model_reset();
    #1 reset_n = 1'b1;
    repeat (2) tick();
    check("post_mask", rd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
